// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the signals that connect the ALU arbiter to its two requesters, to
// the shared single-cycle ALU, and to the response consumer.
//
//   req0_* / req1_*  : operation handshakes (valid/ready + control, a, b)
//   alu_*            : registered ALU inputs and the ALU's result/zero flag
//   rsp_*            : response handshake carrying id, result, zero, err
//
// Modports:
//   slave  - the arbiter's view (consumes requests, drives the ALU inputs and
//            the response)
//   master - the environment's view (requesters, ALU and response consumer)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    // Requester 0
    logic              req0_valid;
    logic              req0_ready;
    logic [CTRL_W-1:0] req0_control;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;

    // Requester 1
    logic              req1_valid;
    logic              req1_ready;
    logic [CTRL_W-1:0] req1_control;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;

    // Shared ALU
    logic [CTRL_W-1:0] alu_control;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_zero;

    // Response
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_zero;
    logic              rsp_err;

    modport slave (
        input  req0_valid, req0_control, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_control, req1_a, req1_b,
        output req1_ready,
        output alu_control, alu_a, alu_b,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_control, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_control, req1_a, req1_b,
        input  req1_ready,
        input  alu_control, alu_a, alu_b,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one single-cycle ALU between two requesters with round-robin
// arbitration. A granted operation is registered onto the ALU inputs, the
// ALU output is captured one cycle later, and the result is returned with the
// requester id through a response handshake. One operation is in flight at a
// time (IDLE -> EXEC -> RESP), so peak throughput is one op per 3 cycles.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - alu_arbiter_if.slave: request handshakes, ALU inputs/outputs,
//            response handshake
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic         clock,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q,       state_d;
    logic              last_grant_q,  last_grant_d;
    logic              id_q,          id_d;
    logic [CTRL_W-1:0] alu_control_q, alu_control_d;
    logic [WIDTH-1:0]  alu_a_q,       alu_a_d;
    logic [WIDTH-1:0]  alu_b_q,       alu_b_d;
    logic              rsp_id_q,      rsp_id_d;
    logic [WIDTH-1:0]  rsp_result_q,  rsp_result_d;
    logic              rsp_zero_q,    rsp_zero_d;
    logic              rsp_err_q,     rsp_err_d;

    logic              grant_sel;
    logic              accept_ok;
    logic              req0_ready;
    logic              req1_ready;

    // Op codes the ALU implements: AND, OR, ADD, SUB, SLT, NOR.
    function automatic logic op_supported(input logic [CTRL_W-1:0] code);
        logic ok;
        ok = 1'b0;
        case (code)
            CTRL_W'(4'b0000): ok = 1'b1;
            CTRL_W'(4'b0001): ok = 1'b1;
            CTRL_W'(4'b0010): ok = 1'b1;
            CTRL_W'(4'b0110): ok = 1'b1;
            CTRL_W'(4'b0111): ok = 1'b1;
            CTRL_W'(4'b1100): ok = 1'b1;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Round-robin pick: a lone requester wins outright; on contention the
    // requester not served last time wins.
    always_comb begin
        grant_sel = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_sel = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant_sel = 1'b1;
        end
    end

    // Readies are gated by reset as well so that both drop the instant reset
    // is asserted, even though the state register already reads IDLE.
    assign accept_ok  = (state_q == IDLE) && !reset;
    assign req0_ready = accept_ok && bus.req0_valid && (grant_sel == 1'b0);
    assign req1_ready = accept_ok && bus.req1_valid && (grant_sel == 1'b1);

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        alu_control_d = alu_control_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_err_d     = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    if (grant_sel) begin
                        alu_control_d = bus.req1_control;
                        alu_a_d       = bus.req1_a;
                        alu_b_d       = bus.req1_b;
                    end else begin
                        alu_control_d = bus.req0_control;
                        alu_a_d       = bus.req0_a;
                        alu_b_d       = bus.req0_b;
                    end
                    id_d         = grant_sel;
                    last_grant_d = grant_sel;
                    state_d      = EXEC;
                end
            end

            EXEC: begin
                // An unsupported code returns a clean zero rather than
                // whatever the ALU happens to drive for it.
                rsp_id_d = id_q;
                if (op_supported(alu_control_q)) begin
                    rsp_result_d = bus.alu_result;
                    rsp_zero_d   = bus.alu_zero;
                    rsp_err_d    = 1'b0;
                end else begin
                    rsp_result_d = '0;
                    rsp_zero_d   = 1'b0;
                    rsp_err_d    = 1'b1;
                end
                state_d = RESP;
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            alu_control_q <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            id_q          <= id_d;
            alu_control_q <= alu_control_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign bus.req0_ready  = req0_ready;
    assign bus.req1_ready  = req1_ready;
    assign bus.alu_control = alu_control_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    // Pure decode of the state register: no path from rsp_ready.
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter with a behavioural ALU attached.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    alu_arbiter_if #(.WIDTH(32), .CTRL_W(4)) bus ();

    alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU. Unsupported codes drive a recognisable junk value with
    // the zero flag set, so the arbiter's scrubbing is visible.
    always_comb begin
        logic [31:0] r;
        logic        z;
        r = 32'hDEADBEEF;
        z = 1'b1;
        case (bus.alu_control)
            4'b0000: begin r = bus.alu_a & bus.alu_b;    z = (r == 32'd0); end
            4'b0001: begin r = bus.alu_a | bus.alu_b;    z = (r == 32'd0); end
            4'b0010: begin r = bus.alu_a + bus.alu_b;    z = (r == 32'd0); end
            4'b0110: begin r = bus.alu_a - bus.alu_b;    z = (r == 32'd0); end
            4'b0111: begin
                r = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
                z = (r == 32'd0);
            end
            4'b1100: begin r = ~(bus.alu_a | bus.alu_b); z = (r == 32'd0); end
            default: begin r = 32'hDEADBEEF;             z = 1'b1;         end
        endcase
        bus.alu_result = r;
        bus.alu_zero   = z;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.req0_valid   = v;
        bus.req0_control = c;
        bus.req0_a       = a;
        bus.req0_b       = b;
    endtask

    task automatic set_req1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.req1_valid   = v;
        bus.req1_control = c;
        bus.req1_a       = a;
        bus.req1_b       = b;
    endtask

    initial begin
        rst = 1'b1;
        set_req0(1'b0, 4'h0, 32'd0, 32'd0);
        set_req1(1'b0, 4'h0, 32'd0, 32'd0);
        bus.rsp_ready = 1'b0;

        // Reset state
        @(negedge clk); #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_alu_ctrl",  32'(bus.alu_control), 0);
        check("rst_alu_a",     bus.alu_a, 0);
        check("rst_alu_b",     bus.alu_b, 0);
        check("rst_rsp_id",    32'(bus.rsp_id), 0);
        check("rst_rsp_res",   bus.rsp_result, 0);
        check("rst_rsp_zero",  32'(bus.rsp_zero), 0);
        check("rst_rsp_err",   32'(bus.rsp_err), 0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Contention: SUB 9-9 vs SLT 3<4, grants alternate 0,1,0,1
        set_req0(1'b1, 4'b0110, 32'd9, 32'd9);
        set_req1(1'b1, 4'b0111, 32'd3, 32'd4);
        bus.rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("cont_rdy0", 32'(bus.req0_ready), (i % 2 == 0) ? 1 : 0);
            check("cont_rdy1", 32'(bus.req1_ready), (i % 2 == 1) ? 1 : 0);
            tick();
            check("cont_exec_rdy", 32'({bus.req0_ready, bus.req1_ready}), 0);
            check("cont_exec_vld", 32'(bus.rsp_valid), 0);
            tick();
            check("cont_vld",  32'(bus.rsp_valid), 1);
            check("cont_id",   32'(bus.rsp_id), (i % 2 == 1) ? 1 : 0);
            check("cont_res",  bus.rsp_result, (i % 2 == 1) ? 1 : 0);
            check("cont_zero", 32'(bus.rsp_zero), (i % 2 == 1) ? 0 : 1);
            check("cont_resp_rdy", 32'({bus.req0_ready, bus.req1_ready}), 0);
            tick();
        end
        set_req0(1'b0, 4'h0, 32'd0, 32'd0);
        set_req1(1'b0, 4'h0, 32'd0, 32'd0);
        bus.rsp_ready = 1'b0;
        #1;

        // Single op: ADD 5+7
        set_req0(1'b1, 4'b0010, 32'd5, 32'd7);
        #1;
        check("add_rdy0", 32'(bus.req0_ready), 1);
        check("add_rdy1", 32'(bus.req1_ready), 0);
        tick();
        check("add_exec_vld", 32'(bus.rsp_valid), 0);
        check("add_alu_ctrl", 32'(bus.alu_control), 2);
        check("add_alu_a",    bus.alu_a, 5);
        check("add_alu_b",    bus.alu_b, 7);
        check("add_exec_rdy", 32'(bus.req0_ready), 0);
        tick();
        check("add_vld",  32'(bus.rsp_valid), 1);
        check("add_res",  bus.rsp_result, 12);
        check("add_zero", 32'(bus.rsp_zero), 0);
        check("add_id",   32'(bus.rsp_id), 0);
        check("add_err",  32'(bus.rsp_err), 0);
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        tick();
        check("add_done_vld", 32'(bus.rsp_valid), 0);
        bus.rsp_ready = 1'b0;

        // Backpressure: req1 OR 0xF0|0x0F, rsp_ready low for 5 cycles
        set_req1(1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
        #1;
        check("bp_rdy1", 32'(bus.req1_ready), 1);
        tick();
        bus.req1_valid = 1'b0;
        set_req0(1'b1, 4'b0010, 32'd1, 32'd1);
        #1;
        check("bp_exec_rdy0", 32'(bus.req0_ready), 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_vld",  32'(bus.rsp_valid), 1);
            check("bp_res",  bus.rsp_result, 32'h0000_00FF);
            check("bp_id",   32'(bus.rsp_id), 1);
            check("bp_rdy0", 32'(bus.req0_ready), 0);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        #1;
        check("bp_last_vld", 32'(bus.rsp_valid), 1);
        tick();
        check("bp_done_vld", 32'(bus.rsp_valid), 0);
        bus.rsp_ready = 1'b0;

        // Unsupported code 0011
        set_req0(1'b1, 4'b0011, 32'd1, 32'd2);
        #1;
        check("bad_rdy0", 32'(bus.req0_ready), 1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        check("bad_vld",  32'(bus.rsp_valid), 1);
        check("bad_err",  32'(bus.rsp_err), 1);
        check("bad_res",  bus.rsp_result, 0);
        check("bad_zero", 32'(bus.rsp_zero), 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // NOR 0,0 after the error
        set_req0(1'b1, 4'b1100, 32'd0, 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        check("nor_vld",  32'(bus.rsp_valid), 1);
        check("nor_res",  bus.rsp_result, 32'hFFFF_FFFF);
        check("nor_err",  32'(bus.rsp_err), 0);
        check("nor_zero", 32'(bus.rsp_zero), 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Valid withdrawal: req1 pulses during EXEC of a req0 AND 3&5
        set_req0(1'b1, 4'b0000, 32'd3, 32'd5);
        tick();
        bus.req0_valid = 1'b0;
        set_req1(1'b1, 4'b0001, 32'd1, 32'd2);
        #1;
        check("wd_exec_rdy1", 32'(bus.req1_ready), 0);
        tick();
        bus.req1_valid = 1'b0;
        check("wd_id",  32'(bus.rsp_id), 0);
        check("wd_res", bus.rsp_result, 1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("wd_idle_vld", 32'(bus.rsp_valid), 0);
        check("wd_alu_a",    bus.alu_a, 3);
        set_req0(1'b1, 4'b0110, 32'd9, 32'd9);
        bus.req1_valid = 1'b1;
        #1;
        check("wd_rr_rdy1", 32'(bus.req1_ready), 1);
        check("wd_rr_rdy0", 32'(bus.req0_ready), 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        check("wd_nogrant_vld", 32'(bus.rsp_valid), 0);
        check("wd_nogrant_a",   bus.alu_a, 3);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        check("wd_again_rdy1", 32'(bus.req1_ready), 1);

        // Reset in the middle of RESP
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        check("mr_vld", 32'(bus.rsp_valid), 1);
        check("mr_res", bus.rsp_result, 3);
        check("mr_id",  32'(bus.rsp_id), 1);
        bus.req0_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("mr_rst_vld",  32'(bus.rsp_valid), 0);
        check("mr_rst_rdy",  32'({bus.req0_ready, bus.req1_ready}), 0);
        check("mr_rst_ctrl", 32'(bus.alu_control), 0);
        check("mr_rst_a",    bus.alu_a, 0);
        check("mr_rst_b",    bus.alu_b, 0);
        check("mr_rst_res",  bus.rsp_result, 0);
        check("mr_rst_id",   32'(bus.rsp_id), 0);
        set_req1(1'b1, 4'b0111, 32'd3, 32'd4);
        tick();
        rst = 1'b0;
        #1;
        check("mr_post_rdy0", 32'(bus.req0_ready), 1);
        check("mr_post_rdy1", 32'(bus.req1_ready), 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        check("mr_post_vld",  32'(bus.rsp_valid), 1);
        check("mr_post_id",   32'(bus.rsp_id), 0);
        check("mr_post_res",  bus.rsp_result, 0);
        check("mr_post_zero", 32'(bus.rsp_zero), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle ALU between two requesters, such as the execute-stage main path and a branch/compare unit, using round-robin arbitration. Each requester presents an operation through a valid/ready handshake. The arbiter registers the operands into the ALU and captures its result. It then returns the result, tagged with the requester id, through a response handshake. The arbiter is the only driver of the ALU's control, a and b inputs.

## Interface

Parameters:
- WIDTH, 32, operand/result width
- CTRL_W, 4, ALU control code width

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  arbiter accepts requester 0 this cycle
- req0_control  input  CTRL_W  ALU op code
- req0_a, req0_b  input  WIDTH  operands
- req1_valid, req1_ready, req1_control, req1_a, req1_b  same as requester 0
- alu_control  output  CTRL_W  registered control to the ALU
- alu_a, alu_b  output  WIDTH  registered operands to the ALU
- alu_result  input  WIDTH  ALU result
- alu_zero  input  1  ALU zero flag
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer takes the response
- rsp_id  output  1  requester that issued the operation
- rsp_result  output  WIDTH  captured result
- rsp_zero  output  1  captured zero flag
- rsp_err  output  1  op code not supported

## Operation

- The FSM has three states: IDLE, EXEC and RESP.
- A register last_grant records which requester was served most recently.
- IDLE:
  - grant_sel = 0 if only req0_valid is asserted; 1 if only req1_valid is asserted.
  - If both are valid, grant_sel = ~last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && (grant_sel==N). This is combinational, and at most one ready is high.
  - On handshake (valid && ready):
    - alu_control/alu_a/alu_b <= the granted request's fields.
    - id_q <= N; last_grant <= N.
    - Go to EXEC.
  - With no valid request, stay in IDLE. The ALU inputs hold their last values.
- EXEC (exactly one cycle):
  - rsp_result <= alu_result; rsp_zero <= alu_zero; rsp_id <= id_q.
  - rsp_err <= 1 when alu_control is not one of 0000, 0001, 0010, 0110, 0111, 1100. In that case rsp_result <= 0 and rsp_zero <= 0 are captured instead, not the stale ALU output.
  - Go to RESP.
- RESP:
  - rsp_valid = 1. The rsp_* outputs and the ALU inputs stay stable.
  - On rsp_ready, go to IDLE.
  - No new request is accepted while in RESP or EXEC; both readies are 0.
- Arithmetic is the ALU's own. The arbiter does not modify the operands or the result.

## Timing

- Reset (asynchronous, immediate):
  - state = IDLE; last_grant = 1, so requester 0 wins the first contention.
  - alu_control = 0000; alu_a = alu_b = 0.
  - rsp_valid = 0; rsp_id = 0; rsp_result = 0; rsp_zero = 0; rsp_err = 0.
- Latency: handshake at edge T; alu_* are valid after T; the result is captured at T+1; rsp_valid is high from T+1 to the edge where rsp_ready is seen.
- Minimum occupancy is 3 cycles per operation (IDLE, EXEC, RESP with rsp_ready already high). Peak throughput is 1 operation per 3 cycles.
- rsp_valid is a registered state decode with no combinational path from rsp_ready. reqN_ready depends combinationally on reqN_valid.
- Backpressure: rsp_ready held low keeps RESP indefinitely. The outputs are frozen and requesters keep waiting.
- Simultaneous events:
  - A request that becomes valid while the arbiter is in RESP is granted in the first IDLE cycle. Round-robin is then applied against the updated last_grant.
  - Requesters may drop valid before ready without penalty; no grant is consumed.
- Reset mid-operation: an in-flight operation or pending response is discarded, rsp_valid drops immediately, and nothing is replayed.

## Test plan

- **Reset:** assert reset mid-RESP → rsp_valid=0 and both readies=0 immediately, alu_control=0000, alu_a=alu_b=0. After release, the first contention grants requester 0.
- **Single op:** req0 ADD a=5, b=7 → req0_ready=1 in the same cycle. rsp_valid rises 1 cycle after the handshake with rsp_result=12, rsp_zero=0, rsp_id=0, rsp_err=0.
- **Contention:** both requesters hold valid, req0 SUB 9-9, req1 SLT 3<4, rsp_ready=1 → grants alternate 0,1,0,1. Responses are (0, result 0, zero 1) and (1, result 1, zero 0), one every 3 cycles.
- **Backpressure:** req1 OR 0xF0|0x0F with rsp_ready=0 for 5 cycles → rsp_valid held and rsp_result=0xFF stable; req0_ready=0 throughout. The response completes the cycle rsp_ready rises.
- **Unsupported code:** req0 control 0011 → rsp_err=1, rsp_result=0, rsp_zero=0. The next valid NOR 0,0 returns 0xFFFFFFFF with rsp_err=0.
- **Valid withdrawal:** req1_valid pulses for 1 cycle while the arbiter is in EXEC → no grant is issued, and last_grant is unchanged.
